spi_regfile_peripheral: RTL
===========================

# spi_regfile_peripheral

Parametrised SPI mode-0 peripheral that fronts a bank of `NUM_REGS` control registers of `DATA_W` bits, with both write and read-back over one serial frame. It sits between the chip's `ui_in` SPI pins and the output/PWM control logic. It supersedes the fixed five-register, write-only peripheral. New behaviour: configurable register count and width, a CIPO read path, strict frame-length checking, and a write strobe.

## Interface
- `NUM_REGS`, 5: number of registers; addresses `0..NUM_REGS-1`.
- `DATA_W`, 8: register and data-field width.
- `ADDR_W`, 7: address-field width; `NUM_REGS <= 2**ADDR_W`.
- `SYNC_STAGES`, 2: synchronizer depth on each input pin; must be ≥2.
- `clk` in 1: single system clock. All logic is on the rising edge.
- `rst_n` in 1: reset, synchronous and active-low.
- `ncs_i` in 1: chip select, active-low, asynchronous to `clk`.
- `sclk_i` in 1: SPI clock, asynchronous to `clk`.
- `copi_i` in 1: controller-out data, asynchronous to `clk`.
- `cipo_o` out 1: peripheral-out data.
- `cipo_oe_o` out 1: CIPO output enable; high only while selected in a read frame.
- `regs_o` out `NUM_REGS*DATA_W`: flattened register bank; register k is at `[k*DATA_W +: DATA_W]`.
- `wr_strobe_o` out 1: one-cycle pulse when a write commits.
- `wr_addr_o` out `ADDR_W`: address of the last committed write.
- `frame_err_o` out 1: one-cycle pulse when a frame is discarded.

## Operation
- Frame format, MSB first: `FRAME_W = 1 + ADDR_W + DATA_W` bits (16 by default).
  - Bit 0 is R/W: 1 = write, 0 = read.
  - Then `ADDR_W` address bits, then `DATA_W` data bits.
- Input conditioning: each pin passes through `SYNC_STAGES` flops. Edges are detected from the last two stages. COPI is sampled from the stage aligned with the detected SCLK rise.
- FSM states:
  - `IDLE`: waits for an nCS fall.
  - `SHIFT`: on each SCLK rise, shifts COPI in and increments `bit_cnt`. Goes to `OVERRUN` when `bit_cnt` would exceed `FRAME_W`.
  - `OVERRUN`: ignores SCLK edges until nCS rises.
  - From any state, an nCS rise returns the FSM to `IDLE`.
- Write commit happens on the synchronized nCS rise, and only if all hold:
  - state is `SHIFT`, `bit_cnt == FRAME_W`, R/W = 1, and address < `NUM_REGS`.
  - On commit: the register updates, `wr_strobe_o` pulses, and `wr_addr_o` is loaded.
  - An in-range-length write to an address ≥ `NUM_REGS` is silently dropped, with no error pulse.
- Read path:
  - When `bit_cnt` reaches `1+ADDR_W` with R/W = 0, the output shift register loads `regs[addr]`, or all zeros if the address is out of range.
  - `cipo_oe_o` rises at that load.
  - `cipo_o` shifts out MSB first, changing on each synchronized SCLK fall. Data bits received during a read are discarded.
- `frame_err_o` pulses on an nCS rise when `bit_cnt != FRAME_W`, or from `OVERRUN`. Read frames are checked the same way.
- nCS rise always clears `bit_cnt`, `cipo_oe_o` and `cipo_o`.

## Timing
- Reset values:
  - `regs_o` = 0, `cipo_o` = 0, `cipo_oe_o` = 0.
  - `wr_strobe_o` = 0, `frame_err_o` = 0, `wr_addr_o` = 0.
  - FSM = `IDLE`, synchronizers = nCS high, SCLK low, COPI low.
- Asserting `rst_n` mid-frame aborts the frame with no commit and no error pulse. The frame in flight is lost even if nCS stays low.
- `f_sclk <= f_clk/8`. nCS setup and hold to SCLK ≥ 1 SCLK half-period.
- Pin to edge-detect latency: `SYNC_STAGES` cycles.
- Write latency: `regs_o` and `wr_strobe_o` update 1 `clk` after the detected nCS rise, i.e. `SYNC_STAGES+1` cycles after the pin rises.
- Read: the first data bit is on `cipo_o` no later than `SYNC_STAGES+2` cycles after the SCLK fall that follows the last address bit. It is therefore valid before the next SCLK rise.
- An nCS fall and rise in the same detected cycle are impossible at this rate limit. If both are seen, the rise wins and the FSM returns to `IDLE`.
- Back-to-back frames need ≥ `SYNC_STAGES+2` cycles of nCS high.

## Structure
- Package `spi_pkg`:
  - state enum (`IDLE`, `SHIFT`, `OVERRUN`);
  - `frame_w(addr_w, data_w)` function;
  - `RW_WRITE`/`RW_READ` constants;
  - default `NUM_REGS`/`DATA_W`/`ADDR_W` localparams.
- Sub-module `spi_sync_edge` (parameter `STAGES`): synchronizer plus rise/fall pulse outputs. It is instantiated for nCS and SCLK, and with edges unused for COPI.

## Test plan
- Write frame R/W=1, addr=0x04, data=0xA5 → `regs_o[39:32]` = 0xA5 and `wr_strobe_o` pulses once with `wr_addr_o` = 4. All other registers remain 0x00.
- Write 0x3C to addr 0x01, then read addr 0x01 → `cipo_oe_o` high during the data phase, and the CIPO bits sampled on SCLK rises give 0x3C.
- 15-bit frame and 17-bit frame, both writes to addr 0x00 with data 0xFF → no update, and `frame_err_o` pulses once for each frame.
- Write 0x77 to addr 0x10 → no register change, no strobe, no error. Read of addr 0x10 returns 0x00.
- `rst_n` low for 2 cycles after 10 bits of a write to addr 0x02, then nCS rises → `regs_o` all zero, no strobe, no error. The next valid frame commits normally.
- `NUM_REGS=16`, `DATA_W=16`, `ADDR_W=7` build: write 0xBEEF to addr 15, then read it back → 0xBEEF in both `regs_o[255:240]` and on CIPO.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI register-file peripheral.
// Contents: FSM state type, frame-width helper, R/W bit encodings and
// default bank geometry.
package spi_pkg;

    localparam int unsigned DEF_NUM_REGS = 5;
    localparam int unsigned DEF_DATA_W   = 8;
    localparam int unsigned DEF_ADDR_W   = 7;

    localparam logic RW_WRITE = 1'b1;
    localparam logic RW_READ  = 1'b0;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SHIFT   = 2'd1,
        OVERRUN = 2'd2
    } spi_state_e;

    // Serial frame length: R/W bit, address field, data field.
    function automatic int unsigned frame_w(input int unsigned addr_w, input int unsigned data_w);
        return 32'd1 + addr_w + data_w;
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for one asynchronous pin, with registered
// rise/fall pulses derived from the last two synchronizer stages.
// Ports:
//   clk, rst_n  : system clock, synchronous active-low reset
//   d_i         : asynchronous pin
//   q_o         : synchronized level, aligned with the rise_o/fall_o pulses
//   rise_o      : one-cycle pulse on a synchronized 0->1 transition
//   fall_o      : one-cycle pulse on a synchronized 1->0 transition
module spi_sync_edge #(
    parameter int unsigned STAGES  = 2,
    parameter logic        RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q, sync_d;
    logic              rise_q, rise_d;
    logic              fall_q, fall_d;

    // Bit 0 is the newest sample; edges compare the two oldest stages.
    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d_i};
        rise_d = sync_q[STAGES-2] & ~sync_q[STAGES-1];
        fall_d = ~sync_q[STAGES-2] & sync_q[STAGES-1];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= {STAGES{RST_VAL}};
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    // The oldest stage holds the post-edge level in the cycle the pulse is high.
    assign q_o    = sync_q[STAGES-1];
    assign rise_o = rise_q;
    assign fall_o = fall_q;

endmodule

// File: rtl/spi_regfile_peripheral.sv
// SPI mode-0 peripheral fronting a bank of NUM_REGS x DATA_W registers.
// Frame (MSB first): R/W (1 = write), ADDR_W address bits, DATA_W data bits.
// Writes commit on nCS rise for exact-length frames to in-range addresses;
// reads shift regs[addr] out on CIPO during the data phase.
// Ports:
//   clk, rst_n            : system clock, synchronous active-low reset
//   ncs_i, sclk_i, copi_i : asynchronous SPI pins
//   cipo_o, cipo_oe_o     : serial read data and its output enable
//   regs_o                : flattened register bank, reg k at [k*DATA_W +: DATA_W]
//   wr_strobe_o, wr_addr_o: commit pulse and address of the last commit
//   frame_err_o           : pulse when a frame is discarded for its length
module spi_regfile_peripheral
    import spi_pkg::*;
#(
    parameter int unsigned NUM_REGS    = DEF_NUM_REGS,
    parameter int unsigned DATA_W      = DEF_DATA_W,
    parameter int unsigned ADDR_W      = DEF_ADDR_W,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       ncs_i,
    input  logic                       sclk_i,
    input  logic                       copi_i,
    output logic                       cipo_o,
    output logic                       cipo_oe_o,
    output logic [NUM_REGS*DATA_W-1:0] regs_o,
    output logic                       wr_strobe_o,
    output logic [ADDR_W-1:0]          wr_addr_o,
    output logic                       frame_err_o
);

    localparam int unsigned FRAME_W = frame_w(ADDR_W, DATA_W);
    localparam int unsigned CNT_W   = $clog2(FRAME_W + 1);

    logic ncs_rise, ncs_fall, ncs_lvl_unused;
    logic sclk_rise, sclk_fall, sclk_lvl_unused;
    logic copi_s, copi_rise_unused, copi_fall_unused;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ncs (
        .clk(clk), .rst_n(rst_n), .d_i(ncs_i),
        .q_o(ncs_lvl_unused), .rise_o(ncs_rise), .fall_o(ncs_fall)
    );
    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst_n(rst_n), .d_i(sclk_i),
        .q_o(sclk_lvl_unused), .rise_o(sclk_rise), .fall_o(sclk_fall)
    );
    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_copi (
        .clk(clk), .rst_n(rst_n), .d_i(copi_i),
        .q_o(copi_s), .rise_o(copi_rise_unused), .fall_o(copi_fall_unused)
    );

    spi_state_e                 state_q, state_d;
    logic [CNT_W-1:0]           bit_cnt_q, bit_cnt_d;
    logic [FRAME_W-1:0]         frame_q, frame_d;
    logic [DATA_W-1:0]          out_q, out_d;
    logic                       cipo_q, cipo_d;
    logic                       oe_q, oe_d;
    logic [NUM_REGS*DATA_W-1:0] regs_q, regs_d;
    logic                       wr_strobe_q, wr_strobe_d;
    logic [ADDR_W-1:0]          wr_addr_q, wr_addr_d;
    logic                       frame_err_q, frame_err_d;
    logic [SYNC_STAGES:0]       warm_q, warm_d;

    logic [FRAME_W-1:0] frame_shift;
    logic [ADDR_W-1:0]  rd_addr, f_addr;
    logic [DATA_W-1:0]  rd_data, f_data;
    logic               rd_rw, f_rw, f_addr_ok, warm;

    // Frame fields: header as it completes during the shift, and the full frame.
    always_comb begin
        frame_shift = {frame_q[FRAME_W-2:0], copi_s};
        rd_rw       = frame_shift[ADDR_W];
        rd_addr     = frame_shift[ADDR_W-1:0];
        f_rw        = frame_q[FRAME_W-1];
        f_addr      = frame_q[DATA_W +: ADDR_W];
        f_data      = frame_q[DATA_W-1:0];
        f_addr_ok   = (32'(f_addr) < NUM_REGS);
        // After reset the synchronizers hold their reset level, not the pin;
        // a pin already low would look like an nCS fall, so starts wait until
        // the oldest stage carries a real sample.
        warm        = warm_q[SYNC_STAGES];
    end

    // Read mux; out-of-range addresses read as zero.
    always_comb begin
        rd_data = '0;
        for (int unsigned k = 0; k < NUM_REGS; k++) begin
            if (32'(rd_addr) == k) rd_data = regs_q[k*DATA_W +: DATA_W];
        end
    end

    // Next-state, shift, read-load and commit logic.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        frame_d     = frame_q;
        out_d       = out_q;
        cipo_d      = cipo_q;
        oe_d        = oe_q;
        regs_d      = regs_q;
        wr_strobe_d = 1'b0;
        wr_addr_d   = wr_addr_q;
        frame_err_d = 1'b0;
        warm_d      = {warm_q[SYNC_STAGES-1:0], 1'b1};

        case (state_q)
            IDLE: begin
                if (ncs_fall && warm) begin
                    state_d   = SHIFT;
                    bit_cnt_d = '0;
                    frame_d   = '0;
                end
            end
            SHIFT: begin
                if (sclk_rise) begin
                    if (32'(bit_cnt_q) == FRAME_W) begin
                        state_d = OVERRUN;
                    end else begin
                        frame_d   = frame_shift;
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        if ((32'(bit_cnt_q) == ADDR_W) && (rd_rw == RW_READ)) begin
                            out_d = rd_data;
                            oe_d  = 1'b1;
                        end
                    end
                end
            end
            OVERRUN: ;
            default: state_d = IDLE;
        endcase

        // CIPO changes on SCLK falls so it is stable at the controller's rise.
        if (oe_q && sclk_fall) begin
            cipo_d = out_q[DATA_W-1];
            out_d  = out_q << 1;
        end

        // nCS rise ends the frame from any state and wins over a same-cycle fall.
        if (ncs_rise) begin
            if ((state_q == SHIFT) && (32'(bit_cnt_q) == FRAME_W)) begin
                if ((f_rw == RW_WRITE) && f_addr_ok) begin
                    for (int unsigned k = 0; k < NUM_REGS; k++) begin
                        if (32'(f_addr) == k) regs_d[k*DATA_W +: DATA_W] = f_data;
                    end
                    wr_strobe_d = 1'b1;
                    wr_addr_d   = f_addr;
                end
            end else if (state_q != IDLE) begin
                frame_err_d = 1'b1;
            end
            state_d   = IDLE;
            bit_cnt_d = '0;
            cipo_d    = 1'b0;
            oe_d      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            frame_q     <= '0;
            out_q       <= '0;
            cipo_q      <= 1'b0;
            oe_q        <= 1'b0;
            regs_q      <= '0;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= '0;
            frame_err_q <= 1'b0;
            warm_q      <= '0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            frame_q     <= frame_d;
            out_q       <= out_d;
            cipo_q      <= cipo_d;
            oe_q        <= oe_d;
            regs_q      <= regs_d;
            wr_strobe_q <= wr_strobe_d;
            wr_addr_q   <= wr_addr_d;
            frame_err_q <= frame_err_d;
            warm_q      <= warm_d;
        end
    end

    assign cipo_o      = cipo_q;
    assign cipo_oe_o   = oe_q;
    assign regs_o      = regs_q;
    assign wr_strobe_o = wr_strobe_q;
    assign wr_addr_o   = wr_addr_q;
    assign frame_err_o = frame_err_q;

endmodule
